// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS PC fetch stage
package mips_pkg;

  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_PLUS4  = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - control/PC bundle of the fetch stage (stat ports under PC_FETCH_STATS_EN)
interface pc_fetch_unit_if #(
  parameter int PC_W = 32
);
  logic            stall_i;
  logic            branch_i;
  logic            zero_i;
  logic            jump_i;
  logic [25:0]     jump_index_i;
  logic [PC_W-1:0] pc_branch_i;
  logic            halt_i;
  logic [PC_W-1:0] pc_o;
  logic [PC_W-1:0] pc_plus4_o;
  logic            pc_valid_o;
  logic            fault_o;
  logic [PC_W-1:0] fault_pc_o;
`ifdef PC_FETCH_STATS_EN
  logic [31:0]     stat_taken_o;
  logic [31:0]     stat_jump_o;
`endif

  modport master (
    output stall_i, branch_i, zero_i, jump_i, jump_index_i, pc_branch_i, halt_i,
`ifdef PC_FETCH_STATS_EN
    input  stat_taken_o, stat_jump_o,
`endif
    input  pc_o, pc_plus4_o, pc_valid_o, fault_o, fault_pc_o
  );

  modport slave (
    input  stall_i, branch_i, zero_i, jump_i, jump_index_i, pc_branch_i, halt_i,
`ifdef PC_FETCH_STATS_EN
    output stat_taken_o, stat_jump_o,
`endif
    output pc_o, pc_plus4_o, pc_valid_o, fault_o, fault_pc_o
  );

endinterface

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC priority select, jump target and misalign flag
module pc_next_sel
  import mips_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [3:0]      pc_region,
  input  logic            branch,
  input  logic            zero,
  input  logic            jump,
  input  logic [25:0]     jump_index,
  input  logic [PC_W-1:0] pc_branch,
  output pc_sel_e         sel,
  output logic [PC_W-1:0] jump_target,
  output logic            misalign
);

  logic taken;

  assign taken       = branch & zero;
  assign jump_target = {pc_region, jump_index, 2'b00};

  // Jump beats a taken branch; a jump also masks any branch misalignment.
  always_comb begin
    sel      = SEL_PLUS4;
    misalign = 1'b0;
    if (jump) begin
      sel = SEL_JUMP;
    end else if (taken) begin
      sel      = SEL_BRANCH;
      misalign = (pc_branch[1:0] != 2'b00);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - MIPS PC register with boot/run/halt/fault sequencing; PC_FETCH_STATS_EN adds branch/jump counters
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          PC_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_fetch_unit_if.slave   bus
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] fault_pc_q, fault_pc_d;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] jump_target;
  pc_sel_e         sel;
  logic            misalign;
  logic            advance;

  assign pc_plus4 = pc_q + PC_W'(PC_INC);

  pc_next_sel #(.PC_W(PC_W)) u_next_sel (
    .pc_region   (pc_plus4[PC_W-1:PC_W-4]),
    .branch      (bus.branch_i),
    .zero        (bus.zero_i),
    .jump        (bus.jump_i),
    .jump_index  (bus.jump_index_i),
    .pc_branch   (bus.pc_branch_i),
    .sel         (sel),
    .jump_target (jump_target),
    .misalign    (misalign)
  );

  // A RUN cycle where control inputs are honoured.
  assign advance = (state_q == RUN) && !bus.stall_i;

  // Next state and next PC; HALT and FAULT freeze everything until reset.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!bus.stall_i) begin
          if (bus.halt_i) begin
            state_d = HALT;
          end else if (misalign) begin
            state_d    = FAULT;
            fault_pc_d = pc_q;
          end else begin
            case (sel)
              SEL_JUMP:   pc_d = jump_target;
              SEL_BRANCH: pc_d = bus.pc_branch_i;
              default:    pc_d = pc_plus4;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  // State, PC and fault-PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= PC_W'(RESET_VECTOR);
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign bus.pc_o       = pc_q;
  assign bus.pc_plus4_o = pc_plus4;
  assign bus.pc_valid_o = (state_q == RUN);
  assign bus.fault_o    = (state_q == FAULT);
  assign bus.fault_pc_o = fault_pc_q;

`ifdef PC_FETCH_STATS_EN
  logic [31:0] stat_taken_q;
  logic [31:0] stat_jump_q;

  // Saturating counters of taken aligned branches and jumps seen in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken_q <= '0;
      stat_jump_q  <= '0;
    end else if (advance) begin
      if (sel == SEL_BRANCH && !misalign && stat_taken_q != 32'hFFFF_FFFF)
        stat_taken_q <= stat_taken_q + 32'd1;
      if (sel == SEL_JUMP && stat_jump_q != 32'hFFFF_FFFF)
        stat_jump_q <= stat_jump_q + 32'd1;
    end
  end

  assign bus.stat_taken_o = stat_taken_q;
  assign bus.stat_jump_o  = stat_jump_q;
`else
  logic unused_advance;
  assign unused_advance = advance;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pc_fetch_unit_if #(.PC_W(32)) bus ();

  pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000), .PC_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall_i      = 1'b0;
    bus.branch_i     = 1'b0;
    bus.zero_i       = 1'b0;
    bus.jump_i       = 1'b0;
    bus.jump_index_i = '0;
    bus.pc_branch_i  = '0;
    bus.halt_i       = 1'b0;
  endtask

  task automatic take_branch(input logic [31:0] tgt);
    bus.branch_i    = 1'b1;
    bus.zero_i      = 1'b1;
    bus.pc_branch_i = tgt;
    tick();
    idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    check_eq("rst_pc", bus.pc_o, 32'h0);
    check_eq("rst_valid", {31'd0, bus.pc_valid_o}, 32'd0);
    check_eq("rst_fault", {31'd0, bus.fault_o}, 32'd0);
    check_eq("rst_fault_pc", bus.fault_pc_o, 32'h0);
    tick();
    rst_n = 1'b1;
    check_eq("boot_valid", {31'd0, bus.pc_valid_o}, 32'd0);
    tick();
    check_eq("run_valid", {31'd0, bus.pc_valid_o}, 32'd1);
    check_eq("run_first_pc", bus.pc_o, 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst_n = 1'b0;
    tick();
    do_reset();

    // Sequential fetch 0, 4, 8, 12
    for (int i = 1; i < 4; i++) begin
      tick();
      check_eq("seq_pc", bus.pc_o, 32'(4 * i));
    end
    check_eq("plus4", bus.pc_plus4_o, 32'd16);

    // Taken branch from 0x40 to 0x80, then not-taken from 0x40
    take_branch(32'h40);
    check_eq("br_to_40", bus.pc_o, 32'h40);
    take_branch(32'h80);
    check_eq("br_taken", bus.pc_o, 32'h80);
    take_branch(32'h40);
    bus.branch_i = 1'b1; bus.zero_i = 1'b0; bus.pc_branch_i = 32'h80;
    tick();
    idle();
    check_eq("br_not_taken", bus.pc_o, 32'h44);

    // Jump wins over a taken branch
    take_branch(32'h1000_0010);
    check_eq("br_to_1000_0010", bus.pc_o, 32'h1000_0010);
    bus.jump_i = 1'b1; bus.jump_index_i = 26'h000_0100;
    bus.branch_i = 1'b1; bus.zero_i = 1'b1; bus.pc_branch_i = 32'h20;
    tick();
    idle();
    check_eq("jump_prio", bus.pc_o, 32'h1000_0400);

    // Jump masks a misaligned taken branch
    bus.jump_i = 1'b1; bus.jump_index_i = 26'h000_0010;
    bus.branch_i = 1'b1; bus.zero_i = 1'b1; bus.pc_branch_i = 32'h23;
    tick();
    idle();
    check_eq("jump_mask_pc", bus.pc_o, 32'h1000_0040);
    check_eq("jump_mask_fault", {31'd0, bus.fault_o}, 32'd0);

    // Wrap-around
    take_branch(32'hFFFF_FFFC);
    check_eq("wrap_plus4", bus.pc_plus4_o, 32'h0);
    tick();
    check_eq("wrap_pc", bus.pc_o, 32'h0);
    tick();
    check_eq("post_wrap_pc", bus.pc_o, 32'h4);

    // Stall with jump/halt presented: PC holds
    bus.stall_i = 1'b1; bus.jump_i = 1'b1; bus.jump_index_i = 26'h3FF; bus.halt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_pc", bus.pc_o, 32'h4);
      check_eq("stall_valid", {31'd0, bus.pc_valid_o}, 32'd1);
    end
    idle();

    // Halt freezes PC and drops valid
    bus.halt_i = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      bus.jump_i = i[0]; bus.jump_index_i = 26'h155; bus.branch_i = 1'b1; bus.zero_i = 1'b1;
      bus.pc_branch_i = 32'h100;
      check_eq("halt_pc", bus.pc_o, 32'h4);
      check_eq("halt_valid", {31'd0, bus.pc_valid_o}, 32'd0);
      tick();
    end
    idle();
    do_reset();

    // Misaligned branch target faults
    take_branch(32'h24);
    check_eq("br_to_24", bus.pc_o, 32'h24);
    take_branch(32'h52);
    check_eq("fault_o", {31'd0, bus.fault_o}, 32'd1);
    check_eq("fault_pc", bus.fault_pc_o, 32'h24);
    check_eq("fault_valid", {31'd0, bus.pc_valid_o}, 32'd0);
    check_eq("fault_pc_hold", bus.pc_o, 32'h24);
    take_branch(32'h60);
    tick();
    check_eq("fault_frozen_pc", bus.pc_o, 32'h24);
    check_eq("fault_sticky", {31'd0, bus.fault_o}, 32'd1);
    do_reset();

    // Asynchronous reset mid-run
    tick();
    tick();
    check_eq("pre_async_pc", bus.pc_o, 32'h8);
    rst_n = 1'b0;
    #1;
    check_eq("async_pc", bus.pc_o, 32'h0);
    check_eq("async_valid", {31'd0, bus.pc_valid_o}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("async_rerun_valid", {31'd0, bus.pc_valid_o}, 32'd1);
    check_eq("async_rerun_pc", bus.pc_o, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter stage of the single-cycle MIPS datapath; sits directly downstream of the branch-target adder and consumes its 32-bit branch target.
- Holds the architectural PC register and drives PC and PC+4 to instruction memory and the branch adder.
- Selects the next PC from PC+4, the taken-branch target or the jump target.
- Sequences boot after reset, supports stall and halt, and faults on a misaligned branch target.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset and presented in BOOT; must be word-aligned.
- PC_W, 32, PC width; fixed at 32 for MIPS32, parameterised only for lint and width checks.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  hold the PC and ignore all control inputs this cycle.
- branch_i  in  1  current instruction is BEQ-class.
- zero_i  in  1  ALU zero flag; branch taken = branch_i & zero_i.
- jump_i  in  1  current instruction is J.
- jump_index_i  in  26  instr[25:0] of a J instruction.
- pc_branch_i  in  32  branch target (PC+4 + SignImm<<2) from the branch adder.
- halt_i  in  1  halt request (e.g. decoded BREAK).
- pc_o  out  32  current PC.
- pc_plus4_o  out  32  pc_o + 4, combinational, wraps modulo 2^32.
- pc_valid_o  out  1  pc_o addresses an instruction to execute this cycle.
- fault_o  out  1  sticky misaligned-target fault.
- fault_pc_o  out  32  PC of the branch that faulted.

Behaviour:
- States: BOOT, RUN, HALT, FAULT, encoded in 2 bits.
- Reset (rst_n low, asynchronous): state=BOOT, pc_o=RESET_VECTOR, pc_valid_o=0, fault_o=0, fault_pc_o=0.
- Reset asserted mid-operation returns to these values immediately, regardless of state.
- BOOT:
  - Lasts exactly one cycle after rst_n deasserts; stall_i is ignored.
  - Next state is RUN; pc_o is unchanged, so the first fetched PC is RESET_VECTOR.
- RUN:
  - pc_valid_o=1.
  - If stall_i=1: pc_o holds, state holds, and halt_i, jump_i and branch_i are all ignored.
  - Else if halt_i=1: next state HALT, pc_o holds.
  - Else next PC is chosen by priority: jump_i, then taken branch, then PC+4.
  - Jump target = {pc_plus4_o[31:28], jump_index_i, 2'b00}.
  - A taken branch with pc_branch_i[1:0]!=0 does not update the PC. Instead: next state FAULT, fault_pc_o<=pc_o, pc_o holds.
  - When jump_i=1 and the branch is also taken, the jump wins and no alignment fault is raised.
- HALT: pc_valid_o=0, pc_o frozen, all inputs ignored; exit only via reset.
- FAULT: pc_valid_o=0, fault_o=1, pc_o and fault_pc_o frozen; exit only via reset.
- Wrap-around: PC 32'hFFFF_FFFC followed by sequential fetch becomes 32'h0000_0000 with no flag.
- Latency: a redirect presented in cycle N is visible on pc_o in cycle N+1.
- pc_plus4_o follows pc_o combinationally.

Optional Feature:
- Macro PC_FETCH_STATS_EN.
- When defined, adds outputs stat_taken_o[31:0] and stat_jump_o[31:0].
  - Counters are reset to 0 by rst_n.
  - stat_taken_o increments on each non-stalled RUN cycle with a taken, aligned, non-jump branch.
  - stat_jump_o increments on each non-stalled RUN cycle with jump_i=1.
  - Both saturate at 32'hFFFF_FFFF.
- When not defined, neither the ports nor the counters exist, and all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - the state enumeration (BOOT, RUN, HALT, FAULT);
  - the next-PC select enumeration (SEL_PLUS4, SEL_BRANCH, SEL_JUMP);
  - the constant PC_INC=4.
- One natural sub-module: pc_next_sel.
  - Purely combinational priority mux.
  - Produces the select, the jump target and the misalign flag.
  - Keeps the top level limited to the state register and the PC register.

Test Plan:
- Reset: hold rst_n low, then release → pc_o=0, pc_valid_o=0 for one cycle, then pc_valid_o=1. Four free cycles → pc_o steps 0, 4, 8, 12.
- Taken branch: pc_o=0x40, branch_i=1, zero_i=1, pc_branch_i=0x80 → next pc_o=0x80. Same stimulus with zero_i=0 → next pc_o=0x44.
- Jump priority: pc_o=0x1000_0010, jump_i=1, jump_index_i=0x000_0100, branch taken with pc_branch_i=0x20 → next pc_o=0x1000_0400.
- Stall and halt: stall_i=1 together with jump_i=1 for 3 cycles → pc_o constant. Then halt_i=1 → pc_valid_o=0 and pc_o frozen for 10 cycles.
- Misaligned branch: pc_o=0x24, branch taken with pc_branch_i=0x52 → fault_o=1, fault_pc_o=0x24, pc_valid_o=0. Pulse rst_n → fault_o=0 and pc_o=RESET_VECTOR.
- Wrap-around and mid-run reset: run from pc_o=0xFFFF_FFFC → next pc_o=0. Assert rst_n low mid-cycle → outputs take reset values before the next clock edge.
